// File: rtl/fixed_adder_arbiter.sv
// fixed_adder_arbiter: round-robin shared saturating add/sub with a registered, backpressured response
module fixed_adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*W-1:0]       req_x_i,
  input  logic [NREQ*W-1:0]       req_y_i,
  input  logic [NREQ-1:0]         req_op_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic [W-1:0]            rsp_z_o,
  output logic                    rsp_ov_o,
  output logic [CNT_W-1:0]        ov_count_o,
  input  logic                    ov_clear_i
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q;
  logic [IW-1:0] ptr_q, ptr_d, id_q, gnt_id;
  logic [IW:0] idx, nxt;
  logic [W-1:0] z_q, z_d, x, y;
  logic [W:0] ex;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ov_q, ov_d, op, found, out_free;
  assign out_free = state_q == EMPTY || rsp_ready_i;
  // First valid requester at or after ptr_q, wrapping; no grant while the response slot is busy
  always_comb begin
    found = 1'b0;
    gnt_id = ptr_q;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      idx = idx >= (IW+1)'(NREQ) ? idx - (IW+1)'(NREQ) : idx;
      if (!found && out_free && req_valid_i[idx[IW-1:0]]) begin
        found = 1'b1;
        gnt_id = idx[IW-1:0];
      end
    end
  end
  // One-hot grant and operand mux for the granted requester
  always_comb begin
    x = '0;
    y = '0;
    op = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = found && gnt_id == IW'(i);
      x = gnt_id == IW'(i) ? req_x_i[i*W +: W] : x;
      y = gnt_id == IW'(i) ? req_y_i[i*W +: W] : y;
      op = gnt_id == IW'(i) ? req_op_i[i] : op;
    end
  end
  // Exact W+1-bit result; top two bits differing means it does not fit and is clamped toward its sign
  always_comb begin
    ex = op ? {x[W-1], x} + {y[W-1], y} : {x[W-1], x} - {y[W-1], y};
    ov_d = ex[W] ^ ex[W-1];
    z_d = ov_d ? {ex[W], {(W-1){~ex[W]}}} : ex[W-1:0];
    nxt = {1'b0, gnt_id} + (IW+1)'(1);
    ptr_d = nxt == (IW+1)'(NREQ) ? '0 : nxt[IW-1:0];
    cnt_d = ov_clear_i ? '0 : (found && ov_d && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // Response FSM, round-robin pointer and overflow counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q <= '0;
      id_q <= '0;
      z_q <= '0;
      ov_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (found) begin
        state_q <= FULL;
        ptr_q <= ptr_d;
        id_q <= gnt_id;
        z_q <= z_d;
        ov_q <= ov_d;
      end else if (rsp_ready_i) begin
        state_q <= EMPTY;
      end
    end
  end
  assign rsp_valid_o = state_q == FULL;
  assign rsp_id_o = id_q;
  assign rsp_z_o = z_q;
  assign rsp_ov_o = ov_q;
  assign ov_count_o = cnt_q;
endmodule

// File: doc/fixed_adder_arbiter.md
Name: fixed_adder_arbiter

Overview:
- Shares one saturating signed add/subtract datapath between NREQ requesters (e.g. PID error, feed-forward and torque-offset paths in the SEA loop).
- Requesters use valid/ready handshakes; the block grants them round-robin.
- Results return on a single registered response channel with backpressure, tagged with the requester index and an overflow flag.
- A saturating overflow-event counter is kept for diagnostics.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand and result width, signed two's complement.
- CNT_W, 16, overflow counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero.
- req_x  in  NREQ*W  packed operand x, requester i at bits [i*W +: W].
- req_y  in  NREQ*W  packed operand y, same packing.
- req_op  in  NREQ  per-requester op: 1 = x+y, 0 = x-y.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  $clog2(NREQ)  index of the requester that produced the result.
- rsp_z  out  W  saturated result.
- rsp_ov  out  1  result was saturated.
- ov_count  out  CNT_W  number of saturated results since reset/clear.
- ov_clear  in  1  synchronous clear of ov_count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_z=0, rsp_ov=0, ov_count=0.
  - Round-robin pointer=0; output FSM in EMPTY.
- Output FSM, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - out_free = EMPTY or (FULL and rsp_ready).
- Arbitration (combinational, every cycle):
  - If out_free, grant the first requester with req_valid=1 searching ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready = one-hot of the grant; all zero if !out_free or no valid request.
  - req_ready must not depend combinationally on its own req_valid bit beyond the grant selection.
- Transfer: occurs for requester g when req_valid[g] and req_ready[g] are both 1. On the next edge:
  - rsp_z, rsp_ov and rsp_id=g are loaded; FSM goes to FULL.
  - ptr becomes (g+1) mod NREQ.
- Latency: exactly one cycle from handshake to rsp_valid.
  - Throughput is one result per cycle while rsp_ready=1.
  - Response accept and a new grant in the same cycle → FSM stays FULL with the new data.
- Response accepted (FULL and rsp_ready) with no new transfer → EMPTY next cycle.
- FULL with rsp_ready=0:
  - rsp_* stay stable and no grants are issued.
  - Pending requesters keep req_valid and their operands held stable (requester obligation).
- ptr changes only on a transfer. Idle cycles leave ptr unchanged.
- Arithmetic:
  - Sign-extend x and y to W+1 bits and form the exact sum or difference.
  - If the top two bits of the exact result are equal: rsp_z = low W bits, rsp_ov=0.
  - Otherwise saturate and set rsp_ov=1:
    - exact result positive → rsp_z = 0111…1;
    - exact result negative → rsp_z = 1000…0.
- ov_count:
  - Increments by 1 on each transfer whose result saturates.
  - Holds at all-ones and never wraps.
  - ov_clear=1 forces 0; clear wins over a simultaneous increment.
- Reset mid-operation: any held response is discarded; no requester is considered served.

Test Plan:
- Single op: requester 2 sends x=100, y=-30, op=1, rsp_ready=1. Expect: req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_z=70, rsp_ov=0.
- Saturation:
  - x=0x7FFFFFF0, y=0x20, op=1 → rsp_z=0x7FFFFFFF, rsp_ov=1, ov_count=1.
  - x=0x80000000, y=1, op=0 → rsp_z=0x80000000, rsp_ov=1, ov_count=2.
- Round robin: all four req_valid held high, rsp_ready=1. Expect grant order 0,1,2,3,0,1 on consecutive cycles, one response per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending. Expect rsp_* constant and req_ready=0 throughout; after rsp_ready=1, next grant is (last_id+1) mod 4.
- Counter limits: CNT_W=4, force 20 saturating ops → ov_count=15. Then ov_clear=1 asserted together with a saturating op → ov_count=0.
- Reset: assert rst_n=0 while FULL → rsp_valid=0 immediately (asynchronous). After release, the first grant goes to the lowest-index valid requester from ptr=0.
